// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution frame controller.
// The drain watchdog is enabled by defining CONV_CTRL_TIMEOUT_EN.
package conv_pkg;

    localparam int unsigned KERNEL_TAPS = 9;
    localparam logic [3:0]  LAST_TAP    = 4'(KERNEL_TAPS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        DONE
    } ctrl_state_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_DIM,
        ERR_ABORT,
        ERR_TIMEOUT
    } ctrl_err_e;

    function automatic logic tap_addr_ok(input logic [3:0] addr);
        return addr <= LAST_TAP;
    endfunction

endpackage

// File: rtl/conv_kernel_shadow.sv
// Shadow bank of the 3x3 kernel taps: one write port from the CPU side and one
// combinational read port used while the taps are streamed into the core.
module conv_kernel_shadow
    import conv_pkg::*;
#(
    parameter int unsigned COEF_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [3:0]        wr_addr_i,
    input  logic [COEF_W-1:0] wr_data_i,
    input  logic [3:0]        rd_addr_i,
    output logic [COEF_W-1:0] rd_data_o
);

    logic [COEF_W-1:0] taps_q [KERNEL_TAPS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < KERNEL_TAPS; i++) begin
                taps_q[i] <= '0;
            end
        end else if (wr_en_i && tap_addr_ok(wr_addr_i)) begin
            taps_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = tap_addr_ok(rd_addr_i) ? taps_q[rd_addr_i] : '0;

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 3x3 convolution core: loads taps, gates W*H input pixels and
// counts (W-2)*(H-2) outputs. Define CONV_CTRL_TIMEOUT_EN to add the drain watchdog.
module conv_frame_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned COEF_W      = 16,
    parameter int unsigned DIM_W       = 8
`ifdef CONV_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cfg_kernel_wr,
    input  logic [3:0]         cfg_kernel_addr,
    input  logic [COEF_W-1:0]  cfg_kernel_data,
    input  logic [DIM_W-1:0]   cfg_frame_w,
    input  logic [DIM_W-1:0]   cfg_frame_h,
    input  logic               start,
    input  logic               abort,
    input  logic               src_valid,
    output logic               src_ready,
    input  logic               sink_full,
    output logic               core_valid_in,
    output logic               core_kernel_wr,
    output logic [3:0]         core_kernel_addr,
    output logic [COEF_W-1:0]  core_kernel_data,
    input  logic               core_valid_out,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err,
    output logic [2*DIM_W-1:0] out_count
);

    localparam int unsigned CNT_W = 2 * DIM_W;

    ctrl_state_e      state_q, state_d;
    ctrl_err_e        err_q, err_d;
    logic [3:0]       load_idx_q, load_idx_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] pix_total_q, pix_total_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             done_q, done_d;

    logic             dims_ok;
    logic             count_out;
    logic [COEF_W-1:0] shadow_rd_data;

`ifdef CONV_CTRL_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC + 1);
    // Cycles elapsed since the last core output (or since DRAIN entry).
    logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

    conv_kernel_shadow #(
        .COEF_W (COEF_W)
    ) u_shadow (
        .clk_i     (clk),
        .rst_ni    (rstn),
        .wr_en_i   (cfg_kernel_wr && !busy),
        .wr_addr_i (cfg_kernel_addr),
        .wr_data_i (cfg_kernel_data),
        .rd_addr_i (load_idx_q),
        .rd_data_o (shadow_rd_data)
    );

    assign busy    = (state_q == LOAD) || (state_q == STREAM) || (state_q == DRAIN);
    assign dims_ok = (cfg_frame_w >= DIM_W'(3)) && (cfg_frame_h >= DIM_W'(3));

    assign src_ready        = (state_q == STREAM) && src_valid && !sink_full;
    assign core_valid_in    = src_ready;
    assign core_kernel_wr   = (state_q == LOAD);
    assign core_kernel_addr = (state_q == LOAD) ? load_idx_q : 4'd0;
    assign core_kernel_data = (state_q == LOAD) ? shadow_rd_data : '0;
    assign done             = done_q;
    assign err              = err_q;
    assign out_count        = out_cnt_q;

    // Outputs saturate at the target so stray pulses cannot push the count past it.
    assign count_out = ((state_q == STREAM) || (state_q == DRAIN)) && core_valid_out &&
                       (out_cnt_q != target_q);

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        load_idx_d  = load_idx_q;
        pix_cnt_d   = pix_cnt_q;
        pix_total_d = pix_total_q;
        target_d    = target_q;
        out_cnt_d   = out_cnt_q;
        done_d      = 1'b0;
`ifdef CONV_CTRL_TIMEOUT_EN
        wdog_d      = '0;
`endif

        if (count_out) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start && !abort) begin
                    if (dims_ok) begin
                        state_d     = LOAD;
                        err_d       = ERR_NONE;
                        load_idx_d  = 4'd0;
                        pix_cnt_d   = '0;
                        out_cnt_d   = '0;
                        pix_total_d = CNT_W'(cfg_frame_w) * CNT_W'(cfg_frame_h);
                        target_d    = CNT_W'(cfg_frame_w - DIM_W'(2)) *
                                      CNT_W'(cfg_frame_h - DIM_W'(2));
                    end else begin
                        err_d = ERR_DIM;
                    end
                end
            end
            LOAD: begin
                if (load_idx_q == LAST_TAP) begin
                    state_d = STREAM;
                end else begin
                    load_idx_d = load_idx_q + 4'd1;
                end
            end
            STREAM: begin
                if (src_ready) begin
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    if (pix_cnt_q == pix_total_q - CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
`ifdef CONV_CTRL_TIMEOUT_EN
                wdog_d = core_valid_out ? WDOG_W'(1) : wdog_q + WDOG_W'(1);
`endif
                if (out_cnt_d == target_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
`ifdef CONV_CTRL_TIMEOUT_EN
                end else if (wdog_d == WDOG_W'(TIMEOUT_CYC)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && busy) begin
            state_d = IDLE;
            err_d   = ERR_ABORT;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            err_q       <= ERR_NONE;
            load_idx_q  <= 4'd0;
            pix_cnt_q   <= '0;
            pix_total_q <= '0;
            target_q    <= '0;
            out_cnt_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            load_idx_q  <= load_idx_d;
            pix_cnt_q   <= pix_cnt_d;
            pix_total_q <= pix_total_d;
            target_q    <= target_d;
            out_cnt_q   <= out_cnt_d;
            done_q      <= done_d;
        end
    end

`ifdef CONV_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed self-checking bench for conv_frame_ctrl; define CONV_CTRL_TIMEOUT_EN to
// also exercise the drain watchdog with a 32-cycle limit.
module tb_conv_frame_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_kernel_wr = 1'b0;
    logic [3:0]  cfg_kernel_addr = 4'd0;
    logic [15:0] cfg_kernel_data = 16'd0;
    logic [7:0]  cfg_frame_w = 8'd0;
    logic [7:0]  cfg_frame_h = 8'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic        sink_full = 1'b0;
    logic        core_valid_in;
    logic        core_kernel_wr;
    logic [3:0]  core_kernel_addr;
    logic [15:0] core_kernel_data;
    logic        core_valid_out = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [15:0] out_count;

    int n_cmp = 0;
    int n_err = 0;

    conv_frame_ctrl #(
        .COEF_W      (16),
        .DIM_W       (8)
`ifdef CONV_CTRL_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (32)
`endif
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .cfg_kernel_wr    (cfg_kernel_wr),
        .cfg_kernel_addr  (cfg_kernel_addr),
        .cfg_kernel_data  (cfg_kernel_data),
        .cfg_frame_w      (cfg_frame_w),
        .cfg_frame_h      (cfg_frame_h),
        .start            (start),
        .abort            (abort),
        .src_valid        (src_valid),
        .src_ready        (src_ready),
        .sink_full        (sink_full),
        .core_valid_in    (core_valid_in),
        .core_kernel_wr   (core_kernel_wr),
        .core_kernel_addr (core_kernel_addr),
        .core_kernel_data (core_kernel_data),
        .core_valid_out   (core_valid_out),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .out_count        (out_count)
    );

    always #5 clk = ~clk;

    // Event monitor, sampled on the falling edge.
    int cyc = 0;
    int pix_seen = 0;
    int done_seen = 0;
    int busy_seen = 0;
    int bad_rdy = 0;
    int kw_total = 0;
    int kaddr_log [128];
    int kdata_log [128];
    int st_cyc = 0;
    int kwr0_cyc = 0;
    int rdy_cyc = 0;
    int done_cyc = 0;
    int out_cyc = 0;
    logic rdy_armed = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (core_valid_in) pix_seen <= pix_seen + 1;
        if (done) begin
            done_seen <= done_seen + 1;
            done_cyc  <= cyc;
        end
        if (busy) busy_seen <= busy_seen + 1;
        if (src_ready && sink_full) bad_rdy <= bad_rdy + 1;
        if (core_valid_out) out_cyc <= cyc;
        if (core_kernel_wr) begin
            kaddr_log[kw_total % 128] <= int'(core_kernel_addr);
            kdata_log[kw_total % 128] <= int'(core_kernel_data);
            kw_total <= kw_total + 1;
            if (core_kernel_addr == 4'd0) kwr0_cyc <= cyc;
        end
        if (start && !busy && !abort) begin
            st_cyc    <= cyc;
            rdy_armed <= 1'b1;
        end else if (rdy_armed && src_ready) begin
            rdy_cyc   <= cyc;
            rdy_armed <= 1'b0;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_tap(input int addr, input int data);
        cfg_kernel_wr   = 1'b1;
        cfg_kernel_addr = 4'(addr);
        cfg_kernel_data = 16'(data);
        tick();
        cfg_kernel_wr   = 1'b0;
    endtask

    task automatic start_frame(input int w, input int h);
        cfg_frame_w = 8'(w);
        cfg_frame_h = 8'(h);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_out(input int n);
        for (int k = 0; k < n; k++) begin
            core_valid_out = 1'b1;
            tick();
            core_valid_out = 1'b0;
            tick();
        end
    endtask

    task automatic wait_pix(input int target);
        int n = 0;
        while (pix_seen < target && n < 500) begin
            tick();
            n++;
        end
        if (pix_seen < target) check("pix_wait_timeout", pix_seen, target);
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_seen <= base && n < 500) begin
            tick();
            n++;
        end
        if (done_seen <= base) check("done_wait_timeout", done_seen, base + 1);
    endtask

    int b_pix, b_done, b_kw, b_busy, b_bad, b_stall, acc;

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_src_ready", int'(src_ready), 0);
        check("rst_kernel_wr", int'(core_kernel_wr), 0);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) wr_tap(i, i + 1);
        wr_tap(9, 16'hDEAD);
        wr_tap(15, 16'hBEEF);

        // 1: nominal 4x4 frame
        src_valid = 1'b1;
        b_pix = pix_seen; b_done = done_seen; b_kw = kw_total;
        start_frame(4, 4);
        wait_pix(b_pix + 16);
        pulse_out(4);
        wait_done(b_done);
        repeat (3) tick();
        check("t1_kw_cnt", kw_total - b_kw, 9);
        for (int i = 0; i < 9; i++) begin
            check("t1_kaddr", kaddr_log[b_kw + i], i);
            check("t1_kdata", kdata_log[b_kw + i], i + 1);
        end
        check("t1_kwr_latency", kwr0_cyc - st_cyc, 1);
        check("t1_rdy_latency", rdy_cyc - st_cyc, 10);
        check("t1_pixels", pix_seen - b_pix, 16);
        check("t1_done_cnt", done_seen - b_done, 1);
        check("t1_out_count", int'(out_count), 4);
        check("t1_err", int'(err), 0);
        check("t1_busy", int'(busy), 0);

        // 2: back-pressure mid-STREAM, one output during the stall, extra outputs after done
        b_pix = pix_seen; b_done = done_seen; b_bad = bad_rdy;
        start_frame(4, 4);
        wait_pix(b_pix + 5);
        sink_full = 1'b1;
        b_stall = pix_seen;
        for (int k = 0; k < 5; k++) begin
            core_valid_out = (k == 0);
            tick();
        end
        core_valid_out = 1'b0;
        check("t2_stall_pixels", pix_seen - b_stall, 0);
        sink_full = 1'b0;
        #1;
        check("t2_rdy_resume", int'(src_ready), 1);
        wait_pix(b_pix + 16);
        pulse_out(3);
        wait_done(b_done);
        pulse_out(2);
        check("t2_bad_rdy", bad_rdy - b_bad, 0);
        check("t2_pixels", pix_seen - b_pix, 16);
        check("t2_done_cnt", done_seen - b_done, 1);
        check("t2_out_count", int'(out_count), 4);

        // 3: bad dimensions
        b_busy = busy_seen; b_kw = kw_total;
        start_frame(2, 8);
        repeat (4) tick();
        check("t3_err_w", int'(err), 1);
        start_frame(8, 2);
        repeat (4) tick();
        check("t3_err_h", int'(err), 1);
        check("t3_busy_seen", busy_seen - b_busy, 0);
        check("t3_kw_cnt", kw_total - b_kw, 0);

        // abort with start while idle: abort wins, nothing starts
        abort = 1'b1;
        start_frame(4, 4);
        abort = 1'b0;
        tick();
        check("abort_start_busy", int'(busy), 0);
        check("abort_start_err", int'(err), 1);

        // 4: abort after 7 pixels, then clean rerun
        b_pix = pix_seen; b_done = done_seen;
        start_frame(4, 4);
        check("t4_err_clr", int'(err), 0);
        wait_pix(b_pix + 7);
        abort = 1'b1;
        src_valid = 1'b0;
        tick();
        abort = 1'b0;
        src_valid = 1'b1;
        check("t4_busy", int'(busy), 0);
        check("t4_err", int'(err), 2);
        check("t4_src_ready", int'(src_ready), 0);
        repeat (5) tick();
        check("t4_pixels", pix_seen - b_pix, 7);
        check("t4_no_done", done_seen - b_done, 0);
        b_pix = pix_seen; b_done = done_seen;
        start_frame(4, 4);
        wait_pix(b_pix + 16);
        pulse_out(4);
        wait_done(b_done);
        check("t4_rerun_err", int'(err), 0);
        check("t4_rerun_pixels", pix_seen - b_pix, 16);
        check("t4_rerun_out", int'(out_count), 4);

        // 5: start and tap write while busy are ignored
        b_pix = pix_seen; b_done = done_seen; b_kw = kw_total;
        start_frame(4, 4);
        wait_pix(b_pix + 3);
        cfg_frame_w = 8'd8;
        cfg_frame_h = 8'd8;
        start = 1'b1;
        wr_tap(0, 16'h00AA);
        start = 1'b0;
        wait_pix(b_pix + 16);
        pulse_out(4);
        wait_done(b_done);
        check("t5_pixels", pix_seen - b_pix, 16);
        check("t5_done_cnt", done_seen - b_done, 1);
        check("t5_kw_cnt", kw_total - b_kw, 9);
        b_pix = pix_seen; b_done = done_seen; b_kw = kw_total;
        start_frame(4, 4);
        wait_pix(b_pix + 16);
        pulse_out(4);
        wait_done(b_done);
        check("t5_tap0_kept", kdata_log[b_kw], 1);

`ifdef CONV_CTRL_TIMEOUT_EN
        // 6: watchdog with only 2 of 4 outputs
        b_pix = pix_seen; b_done = done_seen;
        start_frame(4, 4);
        wait_pix(b_pix + 16);
        pulse_out(2);
        wait_done(b_done);
        check("t6_done_delay", done_cyc - out_cyc, 32);
        check("t6_err", int'(err), 3);
        check("t6_out_count", int'(out_count), 2);
        check("t6_done_cnt", done_seen - b_done, 1);
`endif

        // async reset mid-frame clears everything, shadow taps included
        b_pix = pix_seen;
        start_frame(4, 4);
        wait_pix(b_pix + 3);
        pulse_out(1);
        check("pre_rst_out_count", int'(out_count), 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_src_ready", int'(src_ready), 0);
        check("mid_rst_out_count", int'(out_count), 0);
        tick();
        rstn = 1'b1;
        tick();
        b_pix = pix_seen; b_done = done_seen; b_kw = kw_total;
        start_frame(4, 4);
        wait_pix(b_pix + 16);
        pulse_out(4);
        wait_done(b_done);
        acc = 0;
        for (int i = 0; i < 9; i++) acc = acc | kdata_log[b_kw + i];
        check("rst_taps_cleared", acc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
